// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg
//   Shared definitions for the multiplexed seven-segment driver:
//   - inactive_level(): pin level that leaves an anode/segment dark for a
//     given polarity.
//   - digit_lsb(): LSB position of a digit inside a packed segment bus.
//   - SEG_BLANK_BIT: logical "segment off" value (replicated to blank a digit).
//   - scan_mode_e: whether the slot counter is running or stopped.
package sevenseg_pkg;

  // Logical (pre-polarity) value of an unlit segment.
  localparam logic SEG_BLANK_BIT = 1'b0;

  typedef enum logic {
    SCAN_STOPPED = 1'b0,
    SCAN_RUNNING = 1'b1
  } scan_mode_e;

  // Pin level that keeps a line dark.
  function automatic logic inactive_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

  // Digit d occupies bits [d*seg_width +: seg_width] of a packed pattern bus.
  function automatic int unsigned digit_lsb(input int unsigned digit,
                                            input int unsigned seg_width);
    return digit * seg_width;
  endfunction

endpackage

// File: rtl/sevenseg_pwm.sv
// sevenseg_pwm
//   Free-running BRIGHT_WIDTH-bit counter with a duty compare. Usable for
//   any LED dimming, not only the digit scanner.
// Ports:
//   CLK         clock
//   RSTN        synchronous active-low reset (counter -> 0)
//   brightness  duty; 0 = never on, all-ones = always on
//   on_en       1 while the current cycle falls inside the duty window
module sevenseg_pwm #(
  parameter int BRIGHT_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic [BRIGHT_WIDTH-1:0] brightness,
  output logic                    on_en
);

  logic [BRIGHT_WIDTH-1:0] pwm_count_reg;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      pwm_count_reg <= '0;
    end else begin
      pwm_count_reg <= pwm_count_reg + BRIGHT_WIDTH'(1);
    end
  end

  // All-ones is treated as fully on; a plain compare would leave one dark
  // cycle per PWM period.
  assign on_en = (&brightness) || (pwm_count_reg < brightness);

endmodule

// File: rtl/sevenseg_scanner.sv
// sevenseg_scanner
//   Time-multiplexed driver for NUM_DIGITS seven-segment digits with
//   run-time slot period, per-digit enable, blanking at slot start, PWM
//   brightness and frame-synchronous (tear-free) pattern updates.
// Ports:
//   CLK, RSTN     clock, synchronous active-low reset
//   SEGS_IN       logical patterns (1 = lit), digit i at [i*SEG_WIDTH +: SEG_WIDTH]
//   UPDATE        strobe: stage SEGS_IN, shown from the next frame
//   DIGIT_EN      per-digit enable (live)
//   PERIOD        cycles per digit slot, 0 = scanning stopped
//   BRIGHTNESS    PWM duty
//   ANODES_OUT    anode pins (polarity ANODE_ACTIVE_LOW)
//   SEGMENTS_OUT  segment pins (polarity SEG_ACTIVE_LOW)
//   FRAME_DONE    pulse in the cycle after the last slot of a frame ends
//   UPDATE_ACK    pulse in the cycle after staged data reaches the shadow
module sevenseg_scanner
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int SEG_WIDTH        = 8,
  parameter int PERIOD_WIDTH     = 24,
  parameter int BLANK_CYCLES     = 16,
  parameter int BRIGHT_WIDTH     = 4,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                            CLK,
  input  logic                            RSTN,
  input  logic [NUM_DIGITS*SEG_WIDTH-1:0] SEGS_IN,
  input  logic                            UPDATE,
  input  logic [NUM_DIGITS-1:0]           DIGIT_EN,
  input  logic [PERIOD_WIDTH-1:0]         PERIOD,
  input  logic [BRIGHT_WIDTH-1:0]         BRIGHTNESS,
  output logic [NUM_DIGITS-1:0]           ANODES_OUT,
  output logic [SEG_WIDTH-1:0]            SEGMENTS_OUT,
  output logic                            FRAME_DONE,
  output logic                            UPDATE_ACK
);

  localparam int   DIGIT_W   = $clog2(NUM_DIGITS);
  localparam logic ANODE_OFF = inactive_level(ANODE_ACTIVE_LOW);
  localparam logic SEG_OFF   = inactive_level(SEG_ACTIVE_LOW);

  logic [PERIOD_WIDTH-1:0]         count_reg, count_next;
  logic [DIGIT_W-1:0]              digit_reg, digit_next;
  logic [NUM_DIGITS*SEG_WIDTH-1:0] staging_reg, shadow_reg;
  logic                            pending_reg, ack_reg, frame_done_reg;
  logic [NUM_DIGITS-1:0]           anodes_reg;
  logic [SEG_WIDTH-1:0]            segs_reg;

  scan_mode_e             mode;
  logic                   tick, wrap_tick, boundary, lit, pwm_on;
  logic [SEG_WIDTH-1:0]   shadow_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]  anode_sel;

  sevenseg_pwm #(
    .BRIGHT_WIDTH(BRIGHT_WIDTH)
  ) u_pwm (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .brightness(BRIGHTNESS),
    .on_en     (pwm_on)
  );

  assign mode      = (PERIOD == '0) ? SCAN_STOPPED : SCAN_RUNNING;
  // PERIOD is compared live, so a new value governs the current slot's end.
  assign tick      = (mode == SCAN_RUNNING) && (count_reg == PERIOD - PERIOD_WIDTH'(1));
  assign wrap_tick = tick && (digit_reg == DIGIT_W'(NUM_DIGITS - 1));
  // While stopped there is no frame to tear, so updates pass straight through.
  assign boundary  = wrap_tick || (mode == SCAN_STOPPED);

  // Slot counter / digit index next state.
  always_comb begin
    count_next = count_reg;
    digit_next = digit_reg;
    if (mode == SCAN_RUNNING) begin
      if (tick) begin
        count_next = '0;
        digit_next = wrap_tick ? '0 : digit_reg + DIGIT_W'(1);
      end else if (count_reg >= PERIOD) begin
        // PERIOD shrank below the current count: restart the slot.
        count_next = '0;
      end else begin
        count_next = count_reg + PERIOD_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      count_reg      <= '0;
      digit_reg      <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      count_reg      <= count_next;
      digit_reg      <= digit_next;
      frame_done_reg <= wrap_tick;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign shadow_digit[gi] = shadow_reg[digit_lsb(gi, SEG_WIDTH) +: SEG_WIDTH];
      assign anode_sel[gi]    = (digit_reg == DIGIT_W'(gi));
    end
  endgenerate

  // Disabled digits still consume their slot; they just stay dark.
  assign lit = (mode == SCAN_RUNNING) && DIGIT_EN[digit_reg] &&
               (count_reg >= PERIOD_WIDTH'(BLANK_CYCLES)) && pwm_on;

  // Staging/shadow double buffer: the shadow only changes at a frame boundary.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      staging_reg <= '0;
      shadow_reg  <= '0;
      pending_reg <= 1'b0;
      ack_reg     <= 1'b0;
    end else begin
      ack_reg <= 1'b0;
      if (UPDATE) begin
        staging_reg <= SEGS_IN;
      end
      if (boundary) begin
        if (UPDATE) begin
          // A strobe on the boundary itself is newer than anything staged.
          shadow_reg  <= SEGS_IN;
          pending_reg <= 1'b0;
          ack_reg     <= 1'b1;
        end else if (pending_reg) begin
          shadow_reg  <= staging_reg;
          pending_reg <= 1'b0;
          ack_reg     <= 1'b1;
        end
      end else if (UPDATE) begin
        pending_reg <= 1'b1;
      end
    end
  end

  // Pin registers: logical value XOR inactive level applies polarity.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      anodes_reg <= {NUM_DIGITS{ANODE_OFF}};
      segs_reg   <= {SEG_WIDTH{SEG_OFF}};
    end else begin
      anodes_reg <= (lit ? anode_sel : '0) ^ {NUM_DIGITS{ANODE_OFF}};
      segs_reg   <= (lit ? shadow_digit[digit_reg] : {SEG_WIDTH{SEG_BLANK_BIT}})
                    ^ {SEG_WIDTH{SEG_OFF}};
    end
  end

  assign ANODES_OUT   = anodes_reg;
  assign SEGMENTS_OUT = segs_reg;
  assign FRAME_DONE   = frame_done_reg;
  assign UPDATE_ACK   = ack_reg;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Scoreboard bench for sevenseg_scanner (4 digits, BLANK_CYCLES=1,
// BRIGHT_WIDTH=2, active-low). Stimulus pushes expected pin values and
// expected FRAME_DONE/UPDATE_ACK pulses (with their cycle numbers) into
// queues; monitors compare on the falling edge.
module tb_sevenseg_scanner;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [31:0] SEGS_IN;
  logic        UPDATE;
  logic [3:0]  DIGIT_EN;
  logic [7:0]  PERIOD;
  logic [1:0]  BRIGHTNESS;
  logic [3:0]  ANODES_OUT;
  logic [7:0]  SEGMENTS_OUT;
  logic        FRAME_DONE;
  logic        UPDATE_ACK;

  sevenseg_scanner #(
    .NUM_DIGITS      (4),
    .SEG_WIDTH       (8),
    .PERIOD_WIDTH    (8),
    .BLANK_CYCLES    (1),
    .BRIGHT_WIDTH    (2),
    .ANODE_ACTIVE_LOW(1'b1),
    .SEG_ACTIVE_LOW  (1'b1)
  ) dut (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .SEGS_IN     (SEGS_IN),
    .UPDATE      (UPDATE),
    .DIGIT_EN    (DIGIT_EN),
    .PERIOD      (PERIOD),
    .BRIGHTNESS  (BRIGHTNESS),
    .ANODES_OUT  (ANODES_OUT),
    .SEGMENTS_OUT(SEGMENTS_OUT),
    .FRAME_DONE  (FRAME_DONE),
    .UPDATE_ACK  (UPDATE_ACK)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int cyc; logic fd; logic ack; } ev_t;
  typedef struct { int cyc; logic [3:0] an; logic [7:0] sg; } pin_t;
  ev_t  ev_q[$];
  pin_t pin_q[$];

  localparam logic [31:0] PAT0  = 32'h01020408;
  localparam logic [31:0] PAT_A = 32'h11223344;
  localparam logic [31:0] PAT_B = 32'h5A6B7C0D;
  localparam logic [31:0] PAT_C = 32'h3F065B4F;
  localparam logic [31:0] PAT_D = 32'h666D7D07;

  task automatic push_ev(input int k, input logic fd, input logic ack);
    ev_t e;
    e.cyc = k; e.fd = fd; e.ack = ack;
    ev_q.push_back(e);
  endtask

  task automatic push_dark(input int k);
    pin_t p;
    p.cyc = k; p.an = 4'hF; p.sg = 8'hFF;
    pin_q.push_back(p);
  endtask

  task automatic push_lit(input int k, input int d, input logic [31:0] pat);
    pin_t p;
    logic [31:0] v;
    v = pat;
    p.cyc = k;
    p.an  = ~(4'(1) << d);
    p.sg  = ~v[d*8 +: 8];
    pin_q.push_back(p);
  endtask

  // Expected pins for cycles base+jf .. base+jl where the scan started from
  // count 0 / digit 0 at base+1 with a constant period. PWM counter value
  // used for cycle k is (k-4) mod 4 (reset released after edge 3).
  task automatic push_window(input int base, input int jf, input int jl,
                             input int per, input logic [31:0] pat,
                             input logic [3:0] en, input int br);
    for (int j = jf; j <= jl; j++) begin
      int k, s, d, c, pw;
      k  = base + j;
      s  = j - 1;
      d  = (s / per) % 4;
      c  = s % per;
      pw = (k - 4) % 4;
      if (en[d] && c >= 1 && (br == 3 || pw < br)) push_lit(k, d, pat);
      else push_dark(k);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // Monitor: invariant, pin scoreboard and event scoreboard.
  always @(negedge CLK) begin
    pin_t pe;
    ev_t  ee;
    if (cyc >= 1) begin
      checks++;
      if ($countones(~ANODES_OUT) > 1) begin
        errors++;
        $display("FAIL onehot cyc=%0d anodes=%b (at most one low required)", cyc, ANODES_OUT);
      end
      if (pin_q.size() > 0 && pin_q[0].cyc == cyc) begin
        pe = pin_q.pop_front();
        checks++;
        if (ANODES_OUT !== pe.an || SEGMENTS_OUT !== pe.sg) begin
          errors++;
          $display("FAIL pins cyc=%0d got an=%b sg=%h expected an=%b sg=%h",
                   cyc, ANODES_OUT, SEGMENTS_OUT, pe.an, pe.sg);
        end
      end
      if (FRAME_DONE === 1'b1 || UPDATE_ACK === 1'b1) begin
        checks++;
        if (ev_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d fd=%b ack=%b expected none",
                   cyc, FRAME_DONE, UPDATE_ACK);
        end else begin
          ee = ev_q.pop_front();
          if (ee.cyc != cyc || ee.fd !== FRAME_DONE || ee.ack !== UPDATE_ACK) begin
            errors++;
            $display("FAIL event cyc=%0d fd=%b ack=%b expected cyc=%0d fd=%b ack=%b",
                     cyc, FRAME_DONE, UPDATE_ACK, ee.cyc, ee.fd, ee.ack);
          end else begin
            $display("event cyc=%0d fd=%b ack=%b ok", cyc, FRAME_DONE, UPDATE_ACK);
          end
        end
      end else if (ev_q.size() > 0 && ev_q[0].cyc <= cyc) begin
        ee = ev_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_event cyc=%0d got none expected fd=%b ack=%b",
                 cyc, ee.fd, ee.ack);
      end
    end
  end

  initial begin
    int m, c;
    // Reset and stopped scan.
    RSTN = 1'b0; PERIOD = '0; UPDATE = 1'b0; SEGS_IN = '0;
    DIGIT_EN = 4'hF; BRIGHTNESS = 2'd3;
    for (int k = 1; k <= 10; k++) push_dark(k);
    steps(3);
    RSTN = 1'b1;
    steps(7);

    // Update while stopped loads directly; then scan with PERIOD=4.
    SEGS_IN = PAT0; UPDATE = 1'b1;
    push_ev(cyc + 1, 1'b0, 1'b1);
    step();
    UPDATE = 1'b0;
    PERIOD = 8'd4;
    m = cyc;
    push_window(m, 1, 32, 4, PAT0, 4'hF, 3);
    push_window(m, 33, 48, 4, PAT_B, 4'hF, 3);
    push_ev(m + 16, 1'b1, 1'b0);
    push_ev(m + 32, 1'b1, 1'b1);
    push_ev(m + 48, 1'b1, 1'b0);

    // Tear-free: two updates mid-frame, last wins, one ACK at the boundary.
    steps(21);
    SEGS_IN = PAT_A; UPDATE = 1'b1;
    step();
    UPDATE = 1'b0;
    step();
    SEGS_IN = PAT_B; UPDATE = 1'b1;
    step();
    UPDATE = 1'b0;
    steps(24);

    // PWM and digit enable, PERIOD=8, starting exactly on a frame boundary.
    BRIGHTNESS = 2'd1; DIGIT_EN = 4'b0101; PERIOD = 8'd8;
    m = cyc;
    push_window(m, 1, 95, 8, PAT_B, 4'b0101, 1);
    push_ev(m + 32, 1'b1, 1'b0);
    push_ev(m + 64, 1'b1, 1'b0);
    steps(95);

    // UPDATE on the wrap tick, then PERIOD 8 -> 2 mid-slot (count = 4).
    SEGS_IN = PAT_C; UPDATE = 1'b1; BRIGHTNESS = 2'd3; DIGIT_EN = 4'hF;
    c = cyc;
    push_ev(c + 1, 1'b1, 1'b1);
    push_lit(c + 1, 3, PAT_B);
    push_dark(c + 2);
    for (int k = 3; k <= 6; k++) push_lit(c + k, 0, PAT_C);
    push_dark(c + 7);  push_lit(c + 8, 0, PAT_C);
    push_dark(c + 9);  push_lit(c + 10, 1, PAT_C);
    push_dark(c + 11); push_lit(c + 12, 2, PAT_C);
    push_dark(c + 13); push_lit(c + 14, 3, PAT_C);
    push_dark(c + 15); push_lit(c + 16, 0, PAT_C);
    push_dark(c + 17); push_lit(c + 18, 1, PAT_C);
    push_ev(c + 14, 1'b1, 1'b0);
    step();
    UPDATE = 1'b0;
    steps(4);
    PERIOD = 8'd2;
    steps(11);

    // Reset while an update is pending: no ACK, shadow cleared.
    SEGS_IN = PAT_D; UPDATE = 1'b1;
    step();
    UPDATE = 1'b0;
    step();
    RSTN = 1'b0; PERIOD = '0;
    for (int k = 1; k <= 6; k++) push_dark(cyc + k);
    steps(2);
    RSTN = 1'b1;
    steps(4);
    PERIOD = 8'd2;
    m = cyc;
    push_window(m, 1, 10, 2, 32'h0, 4'hF, 3);
    push_ev(m + 8, 1'b1, 1'b0);
    steps(10);
    @(negedge CLK);
    #1;

    checks++;
    if (pin_q.size() != 0 || ev_q.size() != 0) begin
      errors++;
      $display("FAIL drain pins_left=%0d events_left=%0d expected 0 and 0",
               pin_q.size(), ev_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
